range_gate_framer: RTL and testbench

RANGE_GATE_FRAMER -- requirements
Module: range_gate_framer

---
 rtl/rgf_pkg.sv | 30 +++
 rtl/rgf_sync_fifo.sv | 64 ++++++
 rtl/range_gate_framer.sv | 162 ++++++++++++++++
 tb/tb_range_gate_framer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgf_pkg.sv
// Shared types and widths for the range-gate framer: FSM states, sample and
// gate-index widths, and the word layout carried through the output buffer.
package rgf_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GIDX_W   = 8;
  localparam int DELAY_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] x0;
    logic [SAMPLE_W-1:0] x0z;
    logic                sof;
    logic                eof;
    logic [GIDX_W-1:0]   gidx;
  } pair_t;

  localparam int WORD_W = $bits(pair_t);

  // A shot always covers at least one gate.
  function automatic logic [GIDX_W-1:0] eff_gates(input logic [GIDX_W-1:0] n);
    return (n == '0) ? GIDX_W'(1) : n;
  endfunction

endpackage

// File: rtl/rgf_sync_fifo.sv
// Single-clock FIFO with show-ahead read: the head word is visible on rd_data_o
// whenever the FIFO is non-empty, and reads as zero when empty.
module rgf_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign w_do_rd   = rd_en_i && !empty_o;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_wr   = wr_en_i && (!full_o || w_do_rd);
  assign rd_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by r_count and the read
  // port is masked while empty, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/range_gate_framer.sv
// Cuts a triggered ADC pair stream into fixed-length range gates after a
// programmable delay, tags gate boundaries and buffers pairs behind valid/ready.
module range_gate_framer
  import rgf_pkg::*;
#(
  parameter int GATE_PAIRS = 512,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [SAMPLE_W-1:0] x0_i,
  input  logic [SAMPLE_W-1:0] x0z_i,
  input  logic                trigger_i,
  input  logic [DELAY_W-1:0]  delay_i,
  input  logic [GIDX_W-1:0]   gate_num_i,
  output logic [SAMPLE_W-1:0] dout0_o,
  output logic [SAMPLE_W-1:0] dout1_o,
  output logic                dout_valid_o,
  input  logic                dout_ready_i,
  output logic                sof_o,
  output logic                eof_o,
  output logic [GIDX_W-1:0]   gate_idx_o,
  output logic                busy_o,
  output logic                overflow_o,
  output logic                trig_miss_o
);

  localparam int                PAIR_W    = (GATE_PAIRS > 1) ? $clog2(GATE_PAIRS) : 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(GATE_PAIRS - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DELAY_W-1:0]  r_dly_cnt;
  logic [GIDX_W-1:0]   r_gate_num;
  logic [PAIR_W-1:0]   r_pair_cnt;
  logic [GIDX_W-1:0]   r_gate_cnt;
  logic                w_capture;
  logic                w_last;

  pair_t               w_cap_word;
  pair_t               r_cap;
  logic                r_cap_vld;
  pair_t               w_rd_word;
  logic                w_full;
  logic                w_empty;
  logic                w_rd_en;
  logic                w_drop;
  logic                r_overflow;
  logic                r_trig_miss;

  assign w_last = (r_pair_cnt == LAST_PAIR) && (r_gate_cnt == (r_gate_num - GIDX_W'(1)));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (trigger_i) begin
          w_state_nxt = (delay_i == '0) ? ST_CAPTURE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (r_dly_cnt == DELAY_W'(1)) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shot parameters are latched only on an accepted trigger.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_dly_cnt  <= '0;
      r_gate_num <= '0;
      r_pair_cnt <= '0;
      r_gate_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (trigger_i) begin
            r_dly_cnt  <= delay_i;
            r_gate_num <= eff_gates(gate_num_i);
            r_pair_cnt <= '0;
            r_gate_cnt <= '0;
          end
        end
        ST_DELAY: r_dly_cnt <= r_dly_cnt - DELAY_W'(1);
        ST_CAPTURE: begin
          if (r_pair_cnt == LAST_PAIR) begin
            r_pair_cnt <= '0;
            r_gate_cnt <= r_gate_cnt + GIDX_W'(1);
          end else begin
            r_pair_cnt <= r_pair_cnt + PAIR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_cap_word = '{x0:   x0_i,
                        x0z:  x0z_i,
                        sof:  (r_pair_cnt == '0),
                        eof:  (r_pair_cnt == LAST_PAIR),
                        gidx: r_gate_cnt};

  // Counters keep running when the FIFO drops a pair, so tags stay aligned.
  assign w_rd_en = dout_ready_i && !w_empty;
  assign w_drop  = r_cap_vld && w_full && !w_rd_en;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cap       <= '0;
      r_cap_vld   <= 1'b0;
      r_overflow  <= 1'b0;
      r_trig_miss <= 1'b0;
    end else begin
      if (w_capture) begin
        r_cap <= w_cap_word;
      end
      r_cap_vld   <= w_capture;
      r_overflow  <= r_overflow | w_drop;
      r_trig_miss <= r_trig_miss | (trigger_i && (r_state != ST_IDLE));
    end
  end

  rgf_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (r_cap_vld),
    .wr_data_i (r_cap),
    .rd_en_i   (w_rd_en),
    .rd_data_o (w_rd_word),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign dout0_o      = w_rd_word.x0;
  assign dout1_o      = w_rd_word.x0z;
  assign sof_o        = w_rd_word.sof;
  assign eof_o        = w_rd_word.eof;
  assign gate_idx_o   = w_rd_word.gidx;
  assign dout_valid_o = !w_empty;
  assign busy_o       = (r_state != ST_IDLE);
  assign overflow_o   = r_overflow;
  assign trig_miss_o  = r_trig_miss;

endmodule

// File: tb/tb_range_gate_framer.sv
// Directed bench for range_gate_framer: ramp input, expected pairs derived from
// the trigger cycle and delay, plus stall, overflow, trigger-miss and reset cases.
module tb_range_gate_framer;

  localparam int GP = 512;

  logic        clk_i;
  logic        rst_n_i;
  logic [15:0] x0_i;
  logic [15:0] x0z_i;
  logic        trigger_i;
  logic [15:0] delay_i;
  logic [7:0]  gate_num_i;
  logic [15:0] dout0_o;
  logic [15:0] dout1_o;
  logic        dout_valid_o;
  logic        dout_ready_i;
  logic        sof_o;
  logic        eof_o;
  logic [7:0]  gate_idx_o;
  logic        busy_o;
  logic        overflow_o;
  logic        trig_miss_o;

  range_gate_framer #(
    .GATE_PAIRS (GP),
    .FIFO_DEPTH (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .x0_i         (x0_i),
    .x0z_i        (x0z_i),
    .trigger_i    (trigger_i),
    .delay_i      (delay_i),
    .gate_num_i   (gate_num_i),
    .dout0_o      (dout0_o),
    .dout1_o      (dout1_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .gate_idx_o   (gate_idx_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .trig_miss_o  (trig_miss_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          tgl = 1'b0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [41:0] prev_word = '0;

  logic [15:0] q_x0[$];
  logic [15:0] q_x0z[$];
  logic        q_sof[$];
  logic        q_eof[$];
  logic [7:0]  q_gi[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records every transferred word and flags any change of a stalled word.
  always @(negedge clk_i) begin
    if (prev_stall && !(dout_valid_o &&
        ({dout0_o, dout1_o, sof_o, eof_o, gate_idx_o} == prev_word))) begin
      stall_viol++;
    end
    prev_stall = dout_valid_o && !dout_ready_i;
    prev_word  = {dout0_o, dout1_o, sof_o, eof_o, gate_idx_o};
    if (dout_valid_o && dout_ready_i) begin
      q_x0.push_back(dout0_o);
      q_x0z.push_back(dout1_o);
      q_sof.push_back(sof_o);
      q_eof.push_back(eof_o);
      q_gi.push_back(gate_idx_o);
    end
  end

  // Ramp: the pair presented during cycle n is (2n, 2n+1).
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    x0_i  = 16'(2 * cyc);
    x0z_i = 16'(2 * cyc + 1);
    if (tgl) dout_ready_i = !dout_ready_i;
  endtask

  task automatic clear_q();
    q_x0.delete();
    q_x0z.delete();
    q_sof.delete();
    q_eof.delete();
    q_gi.delete();
  endtask

  task automatic fire(input logic [15:0] d, input logic [7:0] g, output int first);
    trigger_i  = 1'b1;
    delay_i    = d;
    gate_num_i = g;
    first      = 2 * (cyc + int'(d) + 1);
    tick();
    trigger_i  = 1'b0;
    delay_i    = 16'hBEEF;
    gate_num_i = 8'd7;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy_o || dout_valid_o) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(busy_o || dout_valid_o), 64'd0);
  endtask

  task automatic check_stream(input string tag, input int first, input int n_exp);
    int bad_ord = 0;
    int bad_sof = 0;
    int bad_eof = 0;
    int bad_gi  = 0;
    int e;
    check({tag, "_cnt"}, 64'(q_x0.size()), 64'(n_exp));
    if (q_x0.size() > 0) check({tag, "_first"}, 64'(q_x0[0]), 64'(16'(first)));
    for (int i = 0; i < q_x0.size(); i++) begin
      e = first + 2 * i;
      if (q_x0[i] !== 16'(e) || q_x0z[i] !== 16'(e + 1)) bad_ord++;
      if (q_sof[i] !== ((i % GP) == 0)) bad_sof++;
      if (q_eof[i] !== ((i % GP) == GP - 1)) bad_eof++;
      if (q_gi[i] !== 8'(i / GP)) bad_gi++;
    end
    check({tag, "_order"}, 64'(bad_ord), 64'd0);
    check({tag, "_sof"}, 64'(bad_sof), 64'd0);
    check({tag, "_eof"}, 64'(bad_eof), 64'd0);
    check({tag, "_gidx"}, 64'(bad_gi), 64'd0);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({dout0_o, dout1_o, dout_valid_o, sof_o, eof_o, busy_o,
                overflow_o, trig_miss_o, gate_idx_o});
  endfunction

  initial begin
    int first;
    int n;
    int sz;
    int bad;
    rst_n_i      = 1'b0;
    x0_i         = '0;
    x0z_i        = 16'd1;
    trigger_i    = 1'b0;
    delay_i      = '0;
    gate_num_i   = '0;
    dout_ready_i = 1'b1;

    repeat (3) tick();
    check("rst_outs", out_vec(), 64'd0);
    rst_n_i = 1'b1;
    repeat (2) tick();
    check("idle_busy", 64'(busy_o), 64'd0);

    // Two gates after a 10-cycle delay; shot parameters changed after trigger.
    clear_q();
    fire(16'd10, 8'd2, first);
    check("busy_dly", 64'(busy_o), 64'd1);
    wait_idle("t1_tmo", 1500);
    check_stream("t1", first, 2 * GP);

    // Zero delay and gate_num 0 behave as an immediate single gate.
    clear_q();
    fire(16'd0, 8'd0, first);
    check("busy_d0", 64'(busy_o), 64'd1);
    wait_idle("t2_tmo", 1000);
    check_stream("t2", first, GP);
    check("tmiss0", 64'(trig_miss_o), 64'd0);

    // Ready toggling each cycle early in the shot.
    clear_q();
    tgl = 1'b1;
    fire(16'd3, 8'd1, first);
    repeat (100) tick();
    tgl = 1'b0;
    dout_ready_i = 1'b1;
    wait_idle("t3_tmo", 1500);
    check_stream("t3", first, GP);
    check("t3_ovf", 64'(overflow_o), 64'd0);
    check("t3_stall", 64'(stall_viol), 64'd0);

    // Retrigger while capturing is ignored but flagged.
    clear_q();
    fire(16'd2, 8'd1, first);
    repeat (102) tick();
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    check("tmiss1", 64'(trig_miss_o), 64'd1);
    check("t4_busy", 64'(busy_o), 64'd1);
    wait_idle("t4_tmo", 1000);
    check_stream("t4", first, GP);

    // 70 stalled edges with one word resident: 63 more fit, 7 are dropped.
    check("ovf0", 64'(overflow_o), 64'd0);
    clear_q();
    fire(16'd1, 8'd1, first);
    repeat (100) tick();
    dout_ready_i = 1'b0;
    repeat (70) tick();
    check("ovf1", 64'(overflow_o), 64'd1);
    dout_ready_i = 1'b1;
    wait_idle("t5_tmo", 1000);
    check("t5_cnt", 64'(q_x0.size()), 64'(GP - 7));
    bad = 0;
    for (int i = 0; i < q_x0.size(); i++) begin
      if (q_x0z[i] !== q_x0[i] + 16'd1 || q_x0[i][0] !== 1'b0) bad++;
      if (i > 0 && q_x0[i] <= q_x0[i-1]) bad++;
    end
    check("t5_ramp", 64'(bad), 64'd0);
    if (q_x0.size() > 0) begin
      check("t5_first", 64'(q_x0[0]), 64'(16'(first)));
      check("t5_last", 64'(q_x0[q_x0.size()-1]), 64'(16'(first + 2 * (GP - 1))));
    end
    check("t5_stall", 64'(stall_viol), 64'd0);

    // Reset in the middle of a shot.
    clear_q();
    fire(16'd5, 8'd1, first);
    n = 0;
    while (q_x0.size() < 300 && n < 1000) begin
      tick();
      n++;
    end
    check("t6_reach", 64'(q_x0.size() >= 300), 64'd1);
    rst_n_i = 1'b0;
    repeat (3) tick();
    check("t6_rst_outs", out_vec(), 64'd0);
    rst_n_i = 1'b1;
    sz = q_x0.size();
    repeat (50) tick();
    check("t6_quiet", 64'(q_x0.size()), 64'(sz));
    check("t6_valid", 64'(dout_valid_o), 64'd0);
    check("t6_busy", 64'(busy_o), 64'd0);
    check("t6_flags", 64'({overflow_o, trig_miss_o}), 64'd0);

    // A fresh shot after reset frames normally.
    clear_q();
    fire(16'd4, 8'd1, first);
    wait_idle("t7_tmo", 1000);
    check_stream("t7", first, GP);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
